match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter WIN_SCORE, default 11: minimum score that can win a game.
REQ-002 Parameter WIN_MARGIN, default 2: required lead over the opponent to win.
REQ-003 Parameter DISP_PERIOD, default 1000: clock cycles each player's score is displayed (1 s at 1 kHz).
REQ-004 clk_1khz_i  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 point_p1_i  in  1  one-cycle pulse, player 1 scored (from debounced pushbutton path).
REQ-007 point_p2_i  in  1  one-cycle pulse, player 2 scored.
REQ-008 new_game_i  in  1  one-cycle pulse, clear scores and start a new game.
REQ-009 score_p1_o  out  7  player 1 score, binary, 0..99.
REQ-010 score_p2_o  out  7  player 2 score, binary, 0..99.
REQ-011 disp_value_o  out  7  score to feed the binary-to-decimal/7-seg path, 0..99.
REQ-012 disp_sel_o  out  1  player currently shown: 0 = P1, 1 = P2.
REQ-013 disp_blank_o  out  1  1 = display blanked (blink phase).
REQ-014 winner_o  out  2  00 none, 01 P1, 10 P2; 11 never driven.

Function
REQ-015 FSM with two states: PLAY and WON; all outputs registered.
REQ-016 PLAY: single point pulse at cycle n increments that player's score, visible at cycle n+1.
REQ-017 PLAY: point_p1_i and point_p2_i both high in one cycle -> both ignored, no score change.
REQ-018 PLAY -> WON when updated scorer score >= WIN_SCORE and scorer - opponent >= WIN_MARGIN; winner_o set in the same cycle the winning score appears (n+1).
REQ-019 Saturation: a point for a player at 99 leaves the score at 99 and makes that player the winner immediately (PLAY -> WON).
REQ-020 WON: point pulses ignored; scores and winner_o held.
REQ-021 new_game_i in any state -> scores 0, winner_o 00, state PLAY, disp_sel_o 0, timer 0, disp_blank_o 0 at next cycle; new_game_i has priority over same-cycle point pulses.
REQ-022 Display timer counts 0..DISP_PERIOD-1; at terminal count wraps to 0 and, in PLAY, toggles disp_sel_o.
REQ-023 Accepted point in PLAY -> disp_sel_o set to scorer, timer cleared, same cycle as score update.
REQ-024 disp_value_o = score_p1_o when disp_sel_o = 0, else score_p2_o; consistent in every cycle.
REQ-025 WON: disp_sel_o fixed to winner; disp_blank_o toggles at timer terminal count (blink, period 2*DISP_PERIOD); timer cleared on entry, disp_blank_o 0 on entry.
REQ-026 PLAY: disp_blank_o constantly 0.
REQ-027 Score arithmetic on 7-bit unsigned; margin compare without wrap (scorer >= opponent + WIN_MARGIN).

Reset
REQ-028 rst_i high at a clock edge -> state PLAY, scores 0, winner_o 00, disp_sel_o 0, disp_blank_o 0, disp_value_o 0, timer 0.
REQ-029 rst_i has priority over new_game_i and point pulses; reset mid-game discards the game.

Structure
REQ-030 Shared package holds: state encoding (PLAY, WON), winner codes (NONE, P1, P2), MAX_SCORE = 99.
REQ-031 One sub-module, display_rotator: timer, disp_sel_o/disp_blank_o logic, with load-select and clear inputs from the FSM.
REQ-032 Sits between the pushbutton processing and the binary-to-decimal/display path in the top-level scoreboard.

Verification
REQ-033 Reset, then P1 pulses x3, P2 x1 -> score_p1_o 3, score_p2_o 1, winner_o 00, disp_sel_o 1 after last pulse.
REQ-034 P1 pulses x11, P2 none -> winner_o 01 in the cycle score_p1_o becomes 11; further pulses leave 11/0.
REQ-035 Deuce: drive 10-10, then P1, P2, P1, P1 -> 11-10, 11-11, 12-11, 13-11 with winner_o 01 at 13-11 only.
REQ-036 Simultaneous point_p1_i/point_p2_i at 5-5 -> stays 5-5; new_game_i with point_p1_i same cycle -> 0-0, PLAY.
REQ-037 No points, DISP_PERIOD=4 -> disp_sel_o toggles every 4 cycles; after win, disp_blank_o toggles every 4 cycles, disp_sel_o fixed.
REQ-038 Force 99-98 (WIN_SCORE=200), P1 point -> score_p1_o 99, winner_o 01; rst_i mid-game -> all outputs 0 next cycle.

Source files
------------

// File: rtl/match_controller_pkg.sv
// Shared types and constants for the table-tennis match controller.
// Holds the FSM state encoding, winner codes and the score ceiling.
package match_controller_pkg;

  localparam int SCORE_W   = 7;
  localparam int MAX_SCORE = 99;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic {
    PLAY = 1'b0,
    WON  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10
  } winner_t;

  // A two-digit display cannot show more than 99, so the score sticks there.
  function automatic score_t sat_inc(input score_t s);
    return (s >= score_t'(MAX_SCORE)) ? score_t'(MAX_SCORE) : s + 1'b1;
  endfunction

  function automatic logic at_max(input score_t s);
    return s >= score_t'(MAX_SCORE);
  endfunction

endpackage

// File: rtl/match_if.sv
// Bundles the point/new-game pulses and the score/display outputs of the
// match controller; the slave side is the controller, the master side its user.
interface match_if;
  import match_controller_pkg::*;

  logic       point_p1_i;
  logic       point_p2_i;
  logic       new_game_i;
  score_t     score_p1_o;
  score_t     score_p2_o;
  score_t     disp_value_o;
  logic       disp_sel_o;
  logic       disp_blank_o;
  logic [1:0] winner_o;

  modport master (
    output point_p1_i, point_p2_i, new_game_i,
    input  score_p1_o, score_p2_o, disp_value_o,
           disp_sel_o, disp_blank_o, winner_o
  );

  modport slave (
    input  point_p1_i, point_p2_i, new_game_i,
    output score_p1_o, score_p2_o, disp_value_o,
           disp_sel_o, disp_blank_o, winner_o
  );

endinterface

// File: rtl/match_controller_display_rotator.sv
// Display timer: alternates the shown player during play and blinks the
// winner's score once the game is won.
module display_rotator #(
  parameter int DISP_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic load_sel,
  input  logic blink,
  output logic disp_sel,
  output logic disp_blank
);

  localparam int TW = (DISP_PERIOD > 1) ? $clog2(DISP_PERIOD) : 1;
  localparam logic [TW-1:0] TERM = TW'(DISP_PERIOD - 1);

  logic [TW-1:0] timer;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset here is synchronous by design.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      timer      <= '0;
      disp_sel   <= 1'b0;
      disp_blank <= 1'b0;
    end else if (load) begin
      // A scored point shows the scorer for a full period, unblanked.
      timer      <= '0;
      disp_sel   <= load_sel;
      disp_blank <= 1'b0;
    end else if (timer == TERM) begin
      timer <= '0;
      if (blink) disp_blank <= ~disp_blank;
      else       disp_sel   <= ~disp_sel;
    end else begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Match controller: keeps both scores, decides the winner (score and margin,
// or saturation at 99) and drives the score display selection.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int WIN_MARGIN  = 2,
  parameter int DISP_PERIOD = 1000
) (
  input logic   clk_1khz_i,
  input logic   rst_i,
  match_if.slave bus
);

  state_t  state;
  winner_t winner;
  score_t  score_p1;
  score_t  score_p2;
  logic    disp_sel;
  logic    disp_blank;

  logic    p1_acc;
  logic    p2_acc;
  score_t  scorer_cur;
  score_t  scorer_next;
  score_t  opponent;
  logic    win_hit;

  // NOTE: every combinational output gets a default first so no latch can form.
  always_comb begin
    p1_acc      = 1'b0;
    p2_acc      = 1'b0;
    scorer_cur  = '0;
    scorer_next = '0;
    opponent    = '0;
    win_hit     = 1'b0;

    // Simultaneous pulses cancel; new_game outranks any point.
    if (state == PLAY && !bus.new_game_i) begin
      p1_acc = bus.point_p1_i && !bus.point_p2_i;
      p2_acc = bus.point_p2_i && !bus.point_p1_i;
    end

    scorer_cur  = p2_acc ? score_p2 : score_p1;
    opponent    = p2_acc ? score_p1 : score_p2;
    scorer_next = sat_inc(scorer_cur);
    // Compare in int so opponent + margin cannot wrap in 7 bits.
    win_hit = at_max(scorer_cur) ||
              ((int'(scorer_next) >= WIN_SCORE) &&
               (int'(scorer_next) >= int'(opponent) + WIN_MARGIN));
  end

  always_ff @(posedge clk_1khz_i) begin
    if (rst_i || bus.new_game_i) begin
      state    <= PLAY;
      winner   <= NONE;
      score_p1 <= '0;
      score_p2 <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (p1_acc) begin
            score_p1 <= scorer_next;
            if (win_hit) begin
              state  <= WON;
              winner <= P1;
            end
          end else if (p2_acc) begin
            score_p2 <= scorer_next;
            if (win_hit) begin
              state  <= WON;
              winner <= P2;
            end
          end
        end
        WON: begin
          state <= WON;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

  display_rotator #(
    .DISP_PERIOD(DISP_PERIOD)
  ) u_rotator (
    .clk       (clk_1khz_i),
    .rst       (rst_i),
    .clear     (bus.new_game_i),
    .load      (p1_acc || p2_acc),
    .load_sel  (p2_acc),
    .blink     (state == WON),
    .disp_sel  (disp_sel),
    .disp_blank(disp_blank)
  );

  assign bus.score_p1_o   = score_p1;
  assign bus.score_p2_o   = score_p2;
  assign bus.winner_o     = winner;
  assign bus.disp_sel_o   = disp_sel;
  assign bus.disp_blank_o = disp_blank;
  // Muxed from registers so the shown value always tracks disp_sel.
  assign bus.disp_value_o = disp_sel ? score_p2 : score_p1;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: a cycle model feeds a scoreboard queue checked
// every cycle, plus scenario checks on literal expected values.
module tb_match_controller;
  import match_controller_pkg::*;

  localparam int P = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  match_if bus_a ();
  match_if bus_b ();

  match_controller #(.WIN_SCORE(11), .WIN_MARGIN(2), .DISP_PERIOD(P)) dut_a (
    .clk_1khz_i(clk), .rst_i(rst_a), .bus(bus_a)
  );

  match_controller #(.WIN_SCORE(200), .WIN_MARGIN(2), .DISP_PERIOD(P)) dut_b (
    .clk_1khz_i(clk), .rst_i(rst_b), .bus(bus_b)
  );

  typedef struct packed {
    logic [6:0] s1;
    logic [6:0] s2;
    logic [6:0] val;
    logic [1:0] win;
    logic       sel;
    logic       blank;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int m_s1, m_s2, m_win, m_timer;
  bit m_won, m_sel, m_blank;

  // Reference behaviour of dut_a (WIN_SCORE 11, margin 2, period P).
  function automatic exp_t model_step(input bit p1, input bit p2, input bit ng, input bit rst);
    exp_t e;
    if (rst || ng) begin
      m_s1 = 0; m_s2 = 0; m_win = 0; m_timer = 0;
      m_won = 0; m_sel = 0; m_blank = 0;
    end else if (!m_won && (p1 != p2)) begin
      if (p1) begin
        if (m_s1 == 99) begin m_won = 1; m_win = 1; end
        else begin
          m_s1++;
          if (m_s1 >= 11 && m_s1 - m_s2 >= 2) begin m_won = 1; m_win = 1; end
        end
      end else begin
        if (m_s2 == 99) begin m_won = 1; m_win = 2; end
        else begin
          m_s2++;
          if (m_s2 >= 11 && m_s2 - m_s1 >= 2) begin m_won = 1; m_win = 2; end
        end
      end
      m_sel = p2; m_timer = 0; m_blank = 0;
    end else if (m_timer == P - 1) begin
      m_timer = 0;
      if (m_won) m_blank = !m_blank;
      else       m_sel   = !m_sel;
    end else begin
      m_timer++;
    end
    e.s1    = 7'(m_s1);
    e.s2    = 7'(m_s2);
    e.val   = m_sel ? 7'(m_s2) : 7'(m_s1);
    e.win   = 2'(m_win);
    e.sel   = m_sel;
    e.blank = m_blank;
    return e;
  endfunction

  // One clock on dut_a: drive, push expectation, then pop and compare.
  task automatic step(input bit p1, input bit p2, input bit ng, input bit rst);
    exp_t e;
    exp_t got;
    bus_a.point_p1_i = p1;
    bus_a.point_p2_i = p2;
    bus_a.new_game_i = ng;
    rst_a            = rst;
    sb.push_back(model_step(p1, p2, ng, rst));
    @(posedge clk);
    #1;
    bus_a.point_p1_i = 1'b0;
    bus_a.point_p2_i = 1'b0;
    bus_a.new_game_i = 1'b0;
    rst_a            = 1'b0;
    e   = sb.pop_front();
    got = {bus_a.score_p1_o, bus_a.score_p2_o, bus_a.disp_value_o,
           bus_a.winner_o, bus_a.disp_sel_o, bus_a.disp_blank_o};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t got s1=%0d s2=%0d val=%0d win=%b sel=%b blank=%b want s1=%0d s2=%0d val=%0d win=%b sel=%b blank=%b",
               $time, got.s1, got.s2, got.val, got.win, got.sel, got.blank,
               e.s1, e.s2, e.val, e.win, e.sel, e.blank);
    end
  endtask

  task automatic step_b(input bit p1, input bit p2, input bit rst);
    bus_b.point_p1_i = p1;
    bus_b.point_p2_i = p2;
    rst_b            = rst;
    @(posedge clk);
    #1;
    bus_b.point_p1_i = 1'b0;
    bus_b.point_p2_i = 1'b0;
    rst_b            = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 1, 1);
    step(0, 0, 0, 1);
    checks++;
    if ({bus_a.score_p1_o, bus_a.score_p2_o, bus_a.disp_value_o, bus_a.winner_o,
         bus_a.disp_sel_o, bus_a.disp_blank_o} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got s1=%0d s2=%0d win=%b sel=%b want all zero",
               bus_a.score_p1_o, bus_a.score_p2_o, bus_a.winner_o, bus_a.disp_sel_o);
    end
  endtask

  task automatic test_basic();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (bus_a.score_p1_o !== 7'd3 || bus_a.score_p2_o !== 7'd1 ||
        bus_a.winner_o !== 2'b00 || bus_a.disp_sel_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_3_1 got %0d-%0d win=%b sel=%b want 3-1 win=00 sel=1",
               bus_a.score_p1_o, bus_a.score_p2_o, bus_a.winner_o, bus_a.disp_sel_o);
    end
  endtask

  task automatic test_rotate();
    int toggles = 0;
    logic prev;
    prev = bus_a.disp_sel_o;
    for (int i = 0; i < 3 * P; i++) begin
      step(0, 0, 0, 0);
      if (bus_a.disp_sel_o !== prev) toggles++;
      prev = bus_a.disp_sel_o;
    end
    checks++;
    if (toggles != 3) begin
      errors++;
      $display("FAIL rotate_toggles got %0d want 3", toggles);
    end
  endtask

  task automatic test_win_straight();
    step(0, 0, 1, 0);
    for (int i = 1; i <= 11; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (bus_a.winner_o !== ((i == 11) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL straight_winner at %0d got %b", i, bus_a.winner_o);
      end
    end
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (bus_a.score_p1_o !== 7'd11 || bus_a.score_p2_o !== 7'd0 || bus_a.winner_o !== 2'b01) begin
      errors++;
      $display("FAIL won_hold got %0d-%0d win=%b want 11-0 win=01",
               bus_a.score_p1_o, bus_a.score_p2_o, bus_a.winner_o);
    end
  endtask

  task automatic test_blink();
    int toggles = 0;
    int sel_moves = 0;
    logic prev;
    prev = bus_a.disp_blank_o;
    for (int i = 0; i < 2 * P; i++) begin
      step(0, 0, 0, 0);
      if (bus_a.disp_blank_o !== prev) toggles++;
      if (bus_a.disp_sel_o !== 1'b0) sel_moves++;
      prev = bus_a.disp_blank_o;
    end
    checks++;
    if (toggles != 2 || sel_moves != 0) begin
      errors++;
      $display("FAIL blink got toggles=%0d sel_moves=%0d want 2 and 0", toggles, sel_moves);
    end
  endtask

  task automatic test_deuce();
    logic [1:0] want_win [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    bit         seq_p1   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(seq_p1[i], !seq_p1[i], 0, 0);
      checks++;
      if (bus_a.winner_o !== want_win[i]) begin
        errors++;
        $display("FAIL deuce_step%0d at %0d-%0d got win=%b want %b", i,
                 bus_a.score_p1_o, bus_a.score_p2_o, bus_a.winner_o, want_win[i]);
      end
    end
    checks++;
    if (bus_a.score_p1_o !== 7'd13 || bus_a.score_p2_o !== 7'd11) begin
      errors++;
      $display("FAIL deuce_final got %0d-%0d want 13-11", bus_a.score_p1_o, bus_a.score_p2_o);
    end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
    end
    step(1, 1, 0, 0);
    checks++;
    if (bus_a.score_p1_o !== 7'd5 || bus_a.score_p2_o !== 7'd5) begin
      errors++;
      $display("FAIL both_pulses got %0d-%0d want 5-5", bus_a.score_p1_o, bus_a.score_p2_o);
    end
    step(1, 0, 1, 0);
    checks++;
    if (bus_a.score_p1_o !== 7'd0 || bus_a.score_p2_o !== 7'd0 || bus_a.winner_o !== 2'b00) begin
      errors++;
      $display("FAIL new_game_priority got %0d-%0d win=%b want 0-0 win=00",
               bus_a.score_p1_o, bus_a.score_p2_o, bus_a.winner_o);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    checks++;
    if (bus_a.disp_value_o !== 7'd0 || bus_a.score_p1_o !== 7'd0 || bus_a.score_p2_o !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid got val=%0d s1=%0d s2=%0d want 0", bus_a.disp_value_o,
               bus_a.score_p1_o, bus_a.score_p2_o);
    end
  endtask

  task automatic test_saturation();
    step_b(0, 0, 1);
    for (int i = 0; i < 98; i++) begin
      step_b(1, 0, 0);
      step_b(0, 1, 0);
    end
    step_b(1, 0, 0);
    checks++;
    if (bus_b.score_p1_o !== 7'd99 || bus_b.score_p2_o !== 7'd98 || bus_b.winner_o !== 2'b00) begin
      errors++;
      $display("FAIL sat_99_98 got %0d-%0d win=%b want 99-98 win=00",
               bus_b.score_p1_o, bus_b.score_p2_o, bus_b.winner_o);
    end
    step_b(1, 0, 0);
    checks++;
    if (bus_b.score_p1_o !== 7'd99 || bus_b.winner_o !== 2'b01 || bus_b.disp_sel_o !== 1'b0) begin
      errors++;
      $display("FAIL sat_win got s1=%0d win=%b sel=%b want 99 win=01 sel=0",
               bus_b.score_p1_o, bus_b.winner_o, bus_b.disp_sel_o);
    end
    step_b(0, 1, 0);
    checks++;
    if (bus_b.score_p2_o !== 7'd98 || bus_b.winner_o !== 2'b01) begin
      errors++;
      $display("FAIL sat_hold got s2=%0d win=%b want 98 win=01", bus_b.score_p2_o, bus_b.winner_o);
    end
    step_b(0, 0, 1);
    checks++;
    if ({bus_b.score_p1_o, bus_b.score_p2_o, bus_b.disp_value_o, bus_b.winner_o,
         bus_b.disp_sel_o, bus_b.disp_blank_o} !== 25'd0) begin
      errors++;
      $display("FAIL sat_reset got s1=%0d s2=%0d win=%b want all zero",
               bus_b.score_p1_o, bus_b.score_p2_o, bus_b.winner_o);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.point_p1_i = 1'b0;
    bus_a.point_p2_i = 1'b0;
    bus_a.new_game_i = 1'b0;
    bus_b.point_p1_i = 1'b0;
    bus_b.point_p2_i = 1'b0;
    bus_b.new_game_i = 1'b0;
    test_reset();
    test_basic();
    test_rotate();
    test_win_straight();
    test_blink();
    test_deuce();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
